// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: segmented pipelined adder with per-op accurate/approximate mode, exact reference and saturating stats
module approx_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 2,
    parameter int APPROX_BITS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Sum,
    output logic [WIDTH:0]   Exact,
    output logic             err,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int SEG = WIDTH / STAGES;
    logic stall;
    logic deliver;
    logic [CNT_W-1:0] op_q, op_d, errc_q, errc_d;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign deliver  = out_valid && out_ready;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = (k + 1) * SEG;
        logic [WIDTH-1:LO] xi, yi;
        logic              mi, ci, vi;
        logic [WIDTH:0]    ei;
        logic [HI-1:0]     base, sum_d, sum_q;
        logic              c_d, c_q, v_q;
        logic [WIDTH:0]    e_q;
        if (k == 0) begin : g_in
            assign xi   = X;
            assign yi   = Y;
            assign mi   = mode;
            assign ci   = Cin;
            assign vi   = in_valid;
            assign ei   = {1'b0, X} + {1'b0, Y} + (WIDTH + 1)'(Cin);
            assign base = '0;
        end else begin : g_in
            assign xi   = g_stage[k-1].g_fwd.x_q;
            assign yi   = g_stage[k-1].g_fwd.y_q;
            assign mi   = g_stage[k-1].g_fwd.m_q;
            assign ci   = g_stage[k-1].c_q;
            assign vi   = g_stage[k-1].v_q;
            assign ei   = g_stage[k-1].e_q;
            assign base = {{SEG{1'b0}}, g_stage[k-1].sum_q};
        end
        // Ripple this stage's segment; approximated low bits copy Y and pass X as carry
        always_comb begin
            sum_d = base;
            c_d   = ci;
            for (int i = LO; i < HI; i++) begin
                sum_d[i] = (mi && i < APPROX_BITS) ? yi[i] : xi[i] ^ yi[i] ^ c_d;
                c_d      = (mi && i < APPROX_BITS) ? xi[i] : (xi[i] & yi[i]) | ((xi[i] ^ yi[i]) & c_d);
            end
        end
        // Stage register: advances whenever the output is not back-pressured
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
                e_q   <= '0;
            end else if (!stall) begin
                v_q   <= vi;
                sum_q <= sum_d;
                c_q   <= c_d;
                e_q   <= ei;
            end
        end
        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:HI] x_q, y_q;
            logic              m_q;
            // Carry forward only the operand bits later segments still need
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    x_q <= '0;
                    y_q <= '0;
                    m_q <= 1'b0;
                end else if (!stall) begin
                    x_q <= xi[WIDTH-1:HI];
                    y_q <= yi[WIDTH-1:HI];
                    m_q <= mi;
                end
            end
        end
    end
    assign out_valid = g_stage[STAGES-1].v_q;
    assign Sum       = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].sum_q};
    assign Exact     = g_stage[STAGES-1].e_q;
    assign err       = Sum != Exact;
    assign op_count  = op_q;
    assign err_count = errc_q;
    // Saturating statistics; clear wins over a simultaneous delivery
    always_comb begin
        op_d   = stat_clear ? '0 : (deliver && op_q != '1) ? op_q + CNT_W'(1) : op_q;
        errc_d = stat_clear ? '0 : (deliver && err && errc_q != '1) ? errc_q + CNT_W'(1) : errc_q;
    end
    // Statistics registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            errc_q <= '0;
        end else begin
            op_q   <= op_d;
            errc_q <= errc_d;
        end
    end
endmodule

// File: tb/tb_approx_adder_pipe.sv
// tb_approx_adder_pipe: directed table-driven check of approx_adder_pipe (WIDTH=8, STAGES=2, APPROX_BITS=4, CNT_W=4)
module tb_approx_adder_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] X = '0, Y = '0;
    logic       Cin = 1'b0, mode = 1'b0;
    logic       out_valid, out_ready = 1'b1;
    logic [8:0] Sum, Exact;
    logic       err;
    logic       stat_clear = 1'b0;
    logic [3:0] op_count, err_count;

    approx_adder_pipe #(.WIDTH(8), .STAGES(2), .APPROX_BITS(4), .CNT_W(4)) dut (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .Cin(Cin), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Exact(Exact), .err(err), .stat_clear(stat_clear),
        .op_count(op_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [8:0] s;
        logic [8:0] e;
    } vec_t;

    vec_t tbl[13];
    int   checks = 0;
    int   passed = 0;
    int   sq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic drive(input int i);
        in_valid = 1'b1;
        X        = tbl[i].x;
        Y        = tbl[i].y;
        Cin      = tbl[i].c;
        mode     = tbl[i].m;
    endtask

    task automatic check_result(input string tag, input int i);
        chk($sformatf("%s_sum[%0d]", tag, i), Sum, tbl[i].s);
        chk($sformatf("%s_exact[%0d]", tag, i), Exact, tbl[i].e);
        chk($sformatf("%s_err[%0d]", tag, i), err, tbl[i].s != tbl[i].e);
    endtask

    task automatic apply_one(input int i);
        @(negedge clk);
        out_ready = 1'b1;
        drive(i);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("lat_early[%0d]", i), out_valid, 1'b0);
        @(negedge clk);
        chk($sformatf("lat_valid[%0d]", i), out_valid, 1'b1);
        check_result("one", i);
    endtask

    task automatic run_stream(input int st, input int sl);
        int sent = 0;
        int got  = 0;
        int c    = 0;
        while (got < sq.size() && c < 80) begin
            @(negedge clk);
            out_ready = !(c >= st && c < st + sl);
            #1;
            if (out_valid) begin
                check_result("strm", sq[got]);
                if (out_ready) got++;
                else chk("in_ready_stall", in_ready, 1'b0);
            end
            if (sent < sq.size()) begin
                drive(sq[sent]);
                #1;
                if (in_ready) sent++;
            end else in_valid = 1'b0;
            c++;
        end
        if (got < sq.size()) chk("stream_timeout", got, sq.size());
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic clear_stats;
        @(negedge clk);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 9'h100, 9'h100};
        tbl[1]  = '{1'b1, 8'h0F, 8'h01, 1'b0, 9'h011, 9'h010};
        tbl[2]  = '{1'b1, 8'h00, 8'h00, 1'b1, 9'h000, 9'h001};
        tbl[3]  = '{1'b0, 8'hA5, 8'h5A, 1'b1, 9'h100, 9'h100};
        tbl[4]  = '{1'b1, 8'hA5, 8'h5A, 1'b0, 9'h0FA, 9'h0FF};
        tbl[5]  = '{1'b1, 8'hF8, 8'h07, 1'b0, 9'h107, 9'h0FF};
        tbl[6]  = '{1'b1, 8'h34, 8'h12, 1'b0, 9'h042, 9'h046};
        tbl[7]  = '{1'b1, 8'h08, 8'h08, 1'b0, 9'h018, 9'h010};
        tbl[8]  = '{1'b1, 8'h0A, 8'h05, 1'b0, 9'h015, 9'h00F};
        tbl[9]  = '{1'b1, 8'h00, 8'h37, 1'b0, 9'h037, 9'h037};
        tbl[10] = '{1'b0, 8'h80, 8'h80, 1'b1, 9'h101, 9'h101};
        tbl[11] = '{1'b0, 8'h3C, 8'hC3, 1'b0, 9'h0FF, 9'h0FF};
        tbl[12] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 9'h1FF};

        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", Sum, 9'h000);
        chk("rst_exact", Exact, 9'h000);
        chk("rst_err", err, 1'b0);
        chk("rst_op", op_count, 4'd0);
        chk("rst_errc", err_count, 4'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 13; i++) apply_one(i);
        @(negedge clk);
        chk("tbl_op", op_count, 4'd13);
        chk("tbl_errc", err_count, 4'd7);

        clear_stats();
        chk("clr_op", op_count, 4'd0);
        chk("clr_errc", err_count, 4'd0);
        sq = '{0, 1, 10, 9};
        run_stream(0, 0);
        @(negedge clk);
        chk("mix_drained", out_valid, 1'b0);
        chk("mix_op", op_count, 4'd4);
        chk("mix_errc", err_count, 4'd1);

        clear_stats();
        sq = '{3, 4, 5, 6, 7, 11};
        run_stream(3, 5);
        @(negedge clk);
        chk("bp_drained", out_valid, 1'b0);
        chk("bp_op", op_count, 4'd6);
        chk("bp_errc", err_count, 4'd4);

        @(negedge clk);
        out_ready = 1'b0;
        drive(0);
        @(negedge clk);
        drive(1);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sum", Sum, 9'h000);
        chk("mid_rst_exact", Exact, 9'h000);
        chk("mid_rst_op", op_count, 4'd0);
        chk("mid_rst_errc", err_count, 4'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 1'b0);
        end
        chk("post_rst_in_ready", in_ready, 1'b1);

        sq = {};
        for (int i = 0; i < 20; i++) sq.push_back(1);
        run_stream(0, 0);
        @(negedge clk);
        chk("sat_drained", out_valid, 1'b0);
        chk("sat_op", op_count, 4'd15);
        chk("sat_errc", err_count, 4'd15);

        @(negedge clk);
        drive(1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_del_valid", out_valid, 1'b1);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        chk("clr_del_op", op_count, 4'd0);
        chk("clr_del_errc", err_count, 4'd0);
        apply_one(1);
        @(negedge clk);
        chk("post_clr_op", op_count, 4'd1);
        chk("post_clr_errc", err_count, 4'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/approx_adder_pipe.md
# approx_adder_pipe

Parametrised, pipelined adder with a per-operation selectable accurate or lower-part-approximate mode. It is the next generation of the team's 8-bit registered ripple adder. The block splits a WIDTH-bit add into STAGES registered carry segments and runs a valid/ready handshake on both sides. Alongside every result it delivers the exact sum and a mismatch flag, and it keeps saturating operation and error counters for accuracy characterisation.

## Interface
- WIDTH, 16: operand width; must be divisible by STAGES.
- STAGES, 2: pipeline stages; equals the number of carry segments, each WIDTH/STAGES bits. Range 1..WIDTH.
- APPROX_BITS, 4: number of low bits that are approximated in mode 1. Range 0..WIDTH.
- CNT_W, 16: width of each statistics counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operand present.
- in_ready  out  1  block accepts the operand this cycle.
- X, Y  in  WIDTH each  operands.
- Cin  in  1  carry-in.
- mode  in  1  0 = accurate, 1 = approximate low part.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH+1  result in the selected mode; MSB is the carry-out.
- Exact  out  WIDTH+1  X+Y+Cin computed exactly.
- err  out  1  Sum != Exact.
- stat_clear  in  1  synchronous clear of both counters.
- op_count  out  CNT_W  saturating count of delivered results.
- err_count  out  CNT_W  saturating count of delivered results with err=1.

## Operation
- **Accept.** An operand is accepted when in_valid && in_ready. X, Y, Cin and mode travel together through the pipe. Mode is per-operation; mixed-mode streams are legal.
- **Accurate mode (0).** Each bit is a full adder with P=A^B, G=A&B, S=P^c, cout=G|(P&c). Carries ripple through segments. Segment k is computed in stage k from the carry registered at the end of stage k-1. Low-result bits are delayed so that all bits align at the output.
- **Approximate mode (1), bits i < APPROX_BITS.**
  - S[i] = Y[i]; carry out of bit i = X[i].
  - The carry into bit APPROX_BITS is X[APPROX_BITS-1].
  - Cin is ignored.
  - Bits at and above APPROX_BITS use full adders.
  - With APPROX_BITS = 0, mode 1 is identical to mode 0.
  - With APPROX_BITS = WIDTH, Sum[WIDTH] = X[WIDTH-1].
- **Exact path.** Exact is X+Y+Cin at WIDTH+1 bits regardless of mode. It is computed in stage 0 and piped alongside. err = (Sum != Exact); it is always 0 in mode 0.
- **Stall.**
  - stall = out_valid && !out_ready.
  - While stalled, every pipeline register, including valid bits, holds.
  - in_ready = !stall; this is combinational from out_ready.
  - Bubbles are not compressed.
- **Counters.**
  - On out_valid && out_ready, op_count increments by 1, and err_count increments by 1 if err=1.
  - Both counters saturate at 2^CNT_W-1.
  - stat_clear sets both counters to 0 on the next edge. It has priority over a simultaneous delivery, so that result is not counted.
- **Reset.** Reset is asynchronous and may assert at any time, including mid-operation. It clears all stage valid bits, data registers and counters. Operations in flight are discarded with no output.

## Timing
- Reset values: out_valid=0, Sum=0, Exact=0, err=0, op_count=0, err_count=0. in_ready=1 immediately after reset.
- Latency: an operand accepted at edge n produces out_valid=1 with its result after edge n+STAGES-1. With STAGES=1, the output is registered one edge after acceptance, matching the previous generation.
- Throughput: one operation per cycle when out_ready is held high.
- Outputs stay stable while out_valid && !out_ready.
- Results exit in acceptance order. No operation is lost or duplicated across any stall pattern.
- Counters update on the edge of the delivery handshake. They are visible the following cycle.

## Test plan
All scenarios use WIDTH=8, STAGES=2, APPROX_BITS=4.
- **Accurate carry chain.** mode=0, X=0xFF, Y=0x01, Cin=0 → out_valid one cycle after accept with Sum=0x100, Exact=0x100, err=0.
- **Approximate low part.** mode=1, X=0x0F, Y=0x01 → Sum=0x011, Exact=0x010, err=1. Then mode=1, X=0x00, Y=0x00, Cin=1 → Sum=0x000, Exact=0x001, err=1.
- **Mixed stream.**
  - Stimulus: 4 back-to-back operands with alternating mode, out_ready high.
  - Response: 4 consecutive results in order; op_count=4; err_count equals the number of mismatching approximate ops.
- **Back-pressure.**
  - Stimulus: out_ready low from the second result onward for 5 cycles, then high.
  - Response: in_ready low during the stall; Sum/Exact/err held; all results delivered in order with none dropped.
- **Reset mid-flight.**
  - Stimulus: assert reset asynchronously between clock edges with 2 ops in flight.
  - Response: out_valid=0 and counters=0 immediately; no stale result appears after reset releases.
- **Counter saturation and clear.**
  - Stimulus (CNT_W=4): deliver 20 results.
  - Response: op_count stops at 15.
  - Stimulus: assert stat_clear in the same cycle as a delivery.
  - Response: op_count=0, err_count=0 on the next cycle.
